// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and sizing helpers for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } ctrl_state_t;

  localparam int DefaultRegAddrWidth = 4;
  localparam int DefaultWaitLimit    = 16;
  localparam int DefaultCountWidth   = 32;

  // Wait counter must hold WAIT_LIMIT itself.
  function automatic int waitCntWidth(input int waitLimit);
    return (waitLimit < 1) ? 1 : $clog2(waitLimit + 1);
  endfunction

  localparam int DefaultWaitCntWidth = waitCntWidth(DefaultWaitLimit);

endpackage

// File: rtl/sat_counter.sv
// Synchronous-reset up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] countReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      countReg <= '0;
    end else if (inc && (countReg != '1)) begin
      countReg <= countReg + WIDTH'(1);
    end
  end

  assign count = countReg;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait > redirect > load-use,
// with memory-timeout fault escalation and saturating stall/flush counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DefaultRegAddrWidth,
  parameter int WAIT_LIMIT     = DefaultWaitLimit,
  parameter int COUNT_WIDTH    = DefaultCountWidth
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_wr_reg,
  input  logic                      ex_is_load,
  input  logic                      ex_redirect,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  output logic                      pc_wrt_en,
  output logic                      ifid_wrt_en,
  output logic                      idex_wrt_en,
  output logic                      exmem_wrt_en,
  output logic                      memwb_wrt_en,
  output logic                      ifid_flush,
  output logic                      idex_flush,
  output logic                      exmem_flush,
  output logic                      memwb_flush,
  output logic                      fault,
  output logic [COUNT_WIDTH-1:0]    stall_cycles,
  output logic [COUNT_WIDTH-1:0]    flush_events
);

  localparam int WaitW = waitCntWidth(WAIT_LIMIT);
  localparam logic [WaitW-1:0] WaitLimitVal = WaitW'(WAIT_LIMIT);
  localparam logic [WaitW-1:0] WaitOne      = WaitW'(1);

  ctrl_state_t      stateReg, stateNext;
  logic [WaitW-1:0] waitCntReg, waitCntNext;

  logic memWait;
  logic loadUse;
  logic redirectTaken;
  logic stallInc;

  assign memWait = mem_req & ~mem_ready;
  assign loadUse = ex_is_load & ex_wr_reg &
                   ((id_rs1_used & (id_rs1 == ex_rd)) |
                    (id_rs2_used & (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= RUN;
      waitCntReg <= '0;
    end else begin
      stateReg   <= stateNext;
      waitCntReg <= waitCntNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    waitCntNext   = waitCntReg;
    redirectTaken = 1'b0;
    pc_wrt_en     = 1'b1;
    ifid_wrt_en   = 1'b1;
    idex_wrt_en   = 1'b1;
    exmem_wrt_en  = 1'b1;
    memwb_wrt_en  = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    memwb_flush   = 1'b0;

    if (reset || (stateReg == FAULT) ||
        ((stateReg != RUN) && (stateReg != MEM_WAIT))) begin
      // Whole pipeline holds; nothing is bubbled while reset or faulted.
      pc_wrt_en    = 1'b0;
      ifid_wrt_en  = 1'b0;
      idex_wrt_en  = 1'b0;
      exmem_wrt_en = 1'b0;
      memwb_wrt_en = 1'b0;
    end else if (memWait) begin
      // Freeze the front four registers and feed bubbles into WB.
      pc_wrt_en    = 1'b0;
      ifid_wrt_en  = 1'b0;
      idex_wrt_en  = 1'b0;
      exmem_wrt_en = 1'b0;
      memwb_flush  = 1'b1;
      if (stateReg == RUN) begin
        stateNext   = MEM_WAIT;
        waitCntNext = WaitOne;
      end else if (waitCntReg == WaitLimitVal) begin
        stateNext = FAULT;
      end else begin
        waitCntNext = waitCntReg + WaitOne;
      end
    end else begin
      stateNext   = RUN;
      waitCntNext = '0;
      if (ex_redirect) begin
        redirectTaken = 1'b1;
        ifid_flush    = 1'b1;
        idex_flush    = 1'b1;
      end else if (loadUse) begin
        pc_wrt_en   = 1'b0;
        ifid_wrt_en = 1'b0;
        idex_flush  = 1'b1;
      end
    end
  end

  assign fault    = (stateReg == FAULT);
  assign stallInc = ~reset & ~fault & ~pc_wrt_en;

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_stall_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (stallInc),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_flush_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (redirectTaken),
    .count (flush_events)
  );

endmodule
